// File: rtl/sync_fifo_prog_if.sv
// Bundles the FIFO control, data and status signals.
// The master modport is the producer/consumer side. The slave modport is the FIFO itself.
interface sync_fifo_prog_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16
);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic                  flush;
  logic                  err_clear;
  logic [DATA_WIDTH-1:0] data_write;
  logic                  write_enable;
  logic                  read_enable;
  logic [DATA_WIDTH-1:0] data_read;
  logic                  wfull;
  logic                  rempty;
  logic                  half_full;
  logic                  half_rempty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [CntW-1:0]       fill_count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output flush, err_clear, data_write, write_enable, read_enable,
    input  data_read, wfull, rempty, half_full, half_rempty, almost_full, almost_empty,
           fill_count, overflow, underflow
  );

  modport slave (
    input  flush, err_clear, data_write, write_enable, read_enable,
    output data_read, wfull, rempty, half_full, half_rempty, almost_full, almost_empty,
           fill_count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with programmable almost-full/almost-empty thresholds, a fill count,
// sticky overflow/underflow errors, synchronous flush and an optional first-word-fall-through
// read port. The storage is a flop array. All status flags decode the registered fill count.
module sync_fifo_prog #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned DEPTH         = 16,
  parameter int unsigned AFULL_THRESH  = 12,
  parameter int unsigned AEMPTY_THRESH = 4,
  parameter int unsigned FWFT          = 0
) (
  input logic             clk,
  input logic             rst_n,
  sync_fifo_prog_if.slave fifo
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  // Parameters that cannot produce a working FIFO stop elaboration.
  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo_prog: DEPTH must be a power of two and >= 4");
  end
  if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_afull
    $error("sync_fifo_prog: AFULL_THRESH must be in 1..DEPTH");
  end
  if (AEMPTY_THRESH > DEPTH - 1) begin : g_bad_aempty
    $error("sync_fifo_prog: AEMPTY_THRESH must be in 0..DEPTH-1");
  end

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;

  logic full, empty;
  logic wr_acc, rd_acc;

  assign full  = (cnt_q == CntW'(DEPTH));
  assign empty = (cnt_q == '0);

  // Flush swallows any request in the same cycle, so it must also mask acceptance.
  assign wr_acc = fifo.write_enable && !full  && !fifo.flush;
  assign rd_acc = fifo.read_enable  && !empty && !fifo.flush;

  // Next-state for pointers, fill count, registered read data and sticky errors.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    dout_d   = dout_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;

    if (fifo.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({wr_acc, rd_acc})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end

    if (FWFT == 0 && rd_acc) dout_d = mem_q[rd_ptr_q];

    // Clear first so that a new error in the same cycle wins.
    if (fifo.err_clear) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (!fifo.flush && fifo.write_enable && full)  ovf_d = 1'b1;
    if (!fifo.flush && fifo.read_enable  && empty) unf_d = 1'b1;
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      dout_q   <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= fifo.data_write;
  end

  // FWFT shows the head word combinationally. It drives zero when empty to keep the output defined.
  if (FWFT != 0) begin : g_fwft
    assign fifo.data_read = empty ? '0 : mem_q[rd_ptr_q];
  end else begin : g_std
    assign fifo.data_read = dout_q;
  end

  assign fifo.fill_count   = cnt_q;
  assign fifo.wfull        = full;
  assign fifo.rempty       = empty;
  assign fifo.half_full    = (cnt_q >= CntW'(DEPTH / 2));
  assign fifo.half_rempty  = (cnt_q <= CntW'(DEPTH / 2));
  assign fifo.almost_full  = (cnt_q >= CntW'(AFULL_THRESH));
  assign fifo.almost_empty = (cnt_q <= CntW'(AEMPTY_THRESH));
  assign fifo.overflow     = ovf_q;
  assign fifo.underflow    = unf_q;
endmodule

// File: tb/tb_sync_fifo_prog.sv
// Bench for sync_fifo_prog. One instance runs in standard read mode and one in FWFT mode.
// Read data from the standard instance is checked by a scoreboard monitor.
module tb_sync_fifo_prog;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sync_fifo_prog_if #(.DATA_WIDTH(8), .DEPTH(16)) bus0 ();
  sync_fifo_prog_if #(.DATA_WIDTH(8), .DEPTH(16)) bus1 ();

  sync_fifo_prog #(
    .DATA_WIDTH(8), .DEPTH(16), .AFULL_THRESH(12), .AEMPTY_THRESH(4), .FWFT(0)
  ) u_dut0 (
    .clk  (clk),
    .rst_n(rst_n),
    .fifo (bus0)
  );

  sync_fifo_prog #(
    .DATA_WIDTH(8), .DEPTH(16), .AFULL_THRESH(12), .AEMPTY_THRESH(4), .FWFT(1)
  ) u_dut1 (
    .clk  (clk),
    .rst_n(rst_n),
    .fifo (bus1)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_q[$];
  logic       rd_exp = 1'b0;
  logic       rd_pend = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // A read issued with rd_exp set shows its data on data_read after the following edge.
  always @(posedge clk) rd_pend <= rd_exp;

  // Scoreboard monitor: pops one expected word per presented read result.
  always @(negedge clk) begin
    if (rd_pend) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_data: got %0h expected none", bus0.data_read);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (bus0.data_read !== e) begin
          errors++;
          $display("FAIL rd_data: got %0h expected %0h", bus0.data_read, e);
        end
      end
    end
  end

  initial begin
    bus0.flush = 0; bus0.err_clear = 0; bus0.data_write = 0;
    bus0.write_enable = 0; bus0.read_enable = 0;
    bus1.flush = 0; bus1.err_clear = 0; bus1.data_write = 0;
    bus1.write_enable = 0; bus1.read_enable = 0;
    repeat (2) step();
    rst_n = 1'b1;
    step();

    // Reset / idle state
    chk("rst_rempty", bus0.rempty, 1);
    chk("rst_aempty", bus0.almost_empty, 1);
    chk("rst_hrempty", bus0.half_rempty, 1);
    chk("rst_count", bus0.fill_count, 0);
    chk("rst_data", bus0.data_read, 0);
    chk("rst_wfull", bus0.wfull, 0);
    chk("rst_hfull", bus0.half_full, 0);
    chk("rst_afull", bus0.almost_full, 0);
    chk("rst_ovf", bus0.overflow, 0);
    chk("rst_unf", bus0.underflow, 0);
    chk("rst_fwft_rempty", bus1.rempty, 1);

    // Fill 0x00..0x0F, watching the threshold flags rise
    for (int i = 0; i < 16; i++) begin
      bus0.write_enable = 1; bus0.data_write = 8'(i);
      step();
      chk("fill_count", bus0.fill_count, i + 1);
      chk("fill_hfull", bus0.half_full, (i + 1 >= 8) ? 1 : 0);
      chk("fill_afull", bus0.almost_full, (i + 1 >= 12) ? 1 : 0);
      chk("fill_wfull", bus0.wfull, (i + 1 == 16) ? 1 : 0);
    end
    bus0.data_write = 8'hFF;
    step();
    bus0.write_enable = 0;
    chk("ovf_set", bus0.overflow, 1);
    chk("ovf_count", bus0.fill_count, 16);

    // Drain; the scoreboard expects 0x00..0x0F
    for (int i = 0; i < 16; i++) begin
      bus0.read_enable = 1; rd_exp = 1; exp_q.push_back(8'(i));
      step();
      chk("drain_count", bus0.fill_count, 15 - i);
    end
    rd_exp = 0;
    chk("drain_rempty", bus0.rempty, 1);
    chk("drain_aempty", bus0.almost_empty, 1);
    step();
    bus0.read_enable = 0;
    chk("unf_set", bus0.underflow, 1);
    chk("unf_count", bus0.fill_count, 0);
    chk("unf_hold", bus0.data_read, 8'h0F);
    bus0.err_clear = 1;
    step();
    bus0.err_clear = 0;
    chk("clr_ovf", bus0.overflow, 0);
    chk("clr_unf", bus0.underflow, 0);

    // Fill to 5, then run 20 simultaneous write+read cycles across the pointer wrap
    for (int i = 0; i < 5; i++) begin
      bus0.write_enable = 1; bus0.data_write = 8'(8'h40 + i);
      step();
    end
    chk("wrap_pre_count", bus0.fill_count, 5);
    for (int i = 0; i < 20; i++) begin
      bus0.write_enable = 1; bus0.data_write = 8'(8'h45 + i);
      bus0.read_enable = 1; rd_exp = 1; exp_q.push_back(8'(8'h40 + i));
      step();
      chk("wrap_count", bus0.fill_count, 5);
    end
    bus0.write_enable = 0;
    for (int i = 0; i < 5; i++) begin
      bus0.read_enable = 1; rd_exp = 1; exp_q.push_back(8'(8'h54 + i));
      step();
    end
    bus0.read_enable = 0; rd_exp = 0;
    chk("wrap_post_rempty", bus0.rempty, 1);

    // Fill to 10, then flush with a concurrent write
    for (int i = 0; i < 10; i++) begin
      bus0.write_enable = 1; bus0.data_write = 8'(8'h10 + i);
      step();
    end
    chk("pre_flush_count", bus0.fill_count, 10);
    bus0.flush = 1; bus0.data_write = 8'hEE;
    step();
    bus0.flush = 0; bus0.write_enable = 0;
    chk("flush_count", bus0.fill_count, 0);
    chk("flush_rempty", bus0.rempty, 1);
    chk("flush_ovf", bus0.overflow, 0);
    chk("flush_data_hold", bus0.data_read, 8'h58);

    // Write+read while empty: the write lands, the read is rejected
    bus0.write_enable = 1; bus0.read_enable = 1; bus0.data_write = 8'h3C;
    step();
    bus0.write_enable = 0; bus0.read_enable = 0;
    chk("empty_wr_rd_count", bus0.fill_count, 1);
    chk("empty_wr_rd_unf", bus0.underflow, 1);
    bus0.read_enable = 1; rd_exp = 1; exp_q.push_back(8'h3C);
    bus0.err_clear = 1;
    step();
    bus0.read_enable = 0; rd_exp = 0; bus0.err_clear = 0;
    chk("post_3c_rempty", bus0.rempty, 1);
    chk("post_3c_unf", bus0.underflow, 0);

    // FWFT: head word visible without a read
    bus1.write_enable = 1; bus1.data_write = 8'hA5;
    step();
    bus1.write_enable = 0;
    chk("fwft_rempty", bus1.rempty, 0);
    chk("fwft_data", bus1.data_read, 8'hA5);
    step();
    chk("fwft_data_stable", bus1.data_read, 8'hA5);
    bus1.read_enable = 1;
    step();
    bus1.read_enable = 0;
    chk("fwft_pop_rempty", bus1.rempty, 1);
    bus1.write_enable = 1; bus1.data_write = 8'h11;
    step();
    bus1.data_write = 8'h22;
    step();
    bus1.write_enable = 0;
    chk("fwft_head1", bus1.data_read, 8'h11);
    bus1.read_enable = 1;
    step();
    bus1.read_enable = 0;
    chk("fwft_head2", bus1.data_read, 8'h22);
    chk("fwft_count", bus1.fill_count, 1);

    repeat (3) step();
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sync_fifo_prog.md
Name: sync_fifo_prog

Overview:
- Parametrised single-clock FIFO; next generation of the team's 8-bit FIFO block.
- Generalised in data width, depth and read mode (standard or first-word-fall-through).
- Adds programmable almost-full/almost-empty thresholds, a fill count, sticky overflow/underflow errors and a synchronous flush.
- Used as rate buffer inside a single clock domain, e.g. between stimulus driver and DUT-side logic.

Parameters:
DATA_WIDTH, 8, width of data_write/data_read
DEPTH, 16, number of entries; power of two, >= 4
AFULL_THRESH, 12, almost_full asserts when fill_count >= this (1..DEPTH)
AEMPTY_THRESH, 4, almost_empty asserts when fill_count <= this (0..DEPTH-1)
FWFT, 0, 0 = standard read (1-cycle latency), 1 = first-word-fall-through

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous clear of contents and pointers
data_write  input  DATA_WIDTH  write data
write_enable  input  1  write request
read_enable  input  1  read request / pop
data_read  output  DATA_WIDTH  read data
wfull  output  1  fill_count == DEPTH
rempty  output  1  fill_count == 0
half_full  output  1  fill_count >= DEPTH/2
half_rempty  output  1  fill_count <= DEPTH/2
almost_full  output  1  fill_count >= AFULL_THRESH
almost_empty  output  1  fill_count <= AEMPTY_THRESH
fill_count  output  $clog2(DEPTH)+1  stored word count, 0..DEPTH
overflow  output  1  sticky: write attempted while full
underflow  output  1  sticky: read attempted while empty
err_clear  input  1  synchronous clear of overflow/underflow

Behaviour:
- Reset (rst_n low, asynchronous):
  - wr_ptr, rd_ptr, fill_count = 0; data_read = 0; overflow = underflow = 0.
  - Flags: rempty = 1, half_rempty = 1, almost_empty = 1; wfull = half_full = almost_full = 0.
  - Storage array is not reset.
- Storage: flop array of DEPTH x DATA_WIDTH.
- Pointers: $clog2(DEPTH) bits; wrap naturally from DEPTH-1 to 0.
- Acceptance (evaluated on pre-edge state):
  - Write accepted iff write_enable && !wfull.
  - Read accepted iff read_enable && !rempty.
- fill_count update: +1 on write only, -1 on read only, unchanged on both or neither.
- All flags are combinational decodes of the registered fill_count. They therefore reflect the state after each edge, with no extra lag.
- Simultaneous write+read:
  - Non-full, non-empty: both accepted, count unchanged.
  - Full: read accepted, write rejected, overflow set; count becomes DEPTH-1.
  - Empty: write accepted, read rejected, underflow set; count becomes 1.
- Standard mode (FWFT=0):
  - On accepted read, data_read <= mem[rd_ptr] at that edge, i.e. valid the cycle after read_enable.
  - data_read holds its value otherwise, including on rejected reads.
- FWFT mode (FWFT=1):
  - data_read = mem[rd_ptr] combinationally whenever !rempty, so the head word is visible with zero latency.
  - read_enable pops it.
  - data_read is don't-care while rempty.
- Errors:
  - overflow/underflow set on the rejected attempt and stay set until err_clear.
  - If err_clear and a new error occur in the same cycle, set wins.
- flush:
  - Pointers and fill_count -> 0 at the next edge.
  - Any write/read that cycle is ignored and raises no error.
  - data_read and the error flags are unchanged.
- Reset mid-operation: immediate return to reset values; contents are lost logically.
- Threshold legality: AFULL_THRESH and AEMPTY_THRESH outside their legal ranges is an elaboration error (assert).

Test Plan:
- Reset then idle -> rempty=1, almost_empty=1, half_rempty=1, fill_count=0, data_read=0, all other outputs 0.
- DEPTH=16: write 0x00..0x0F back-to-back.
  - half_full rises after the 8th write; almost_full after the 12th; wfull after the 16th.
  - A 17th write sets overflow; fill_count stays 16.
- Full FIFO, drain with read_enable (FWFT=0) -> data_read = 0x00..0x0F, each one cycle after its read.
  - rempty after the 16th read; a 17th read sets underflow; err_clear clears both errors.
- Fill to 5, then 20 cycles of simultaneous write+read with incrementing data -> fill_count stays 5, output order preserved.
  - Pointers wrap past 15 with no corruption.
- FWFT=1: single write of 0xA5 -> next cycle rempty=0 and data_read=0xA5 with no read issued; read_enable pops it and rempty=1.
- Fill to 10, assert flush together with write_enable -> fill_count=0, rempty=1, no overflow.
  - Subsequent write/read of 0x3C returns 0x3C.
